// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Opcode constants, immediate-format codes and decode FSM state type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] C_IMM_OP_IMM = 3'd0;
    localparam logic [2:0] C_IMM_LOAD   = 3'd1;
    localparam logic [2:0] C_IMM_STORE  = 3'd2;
    localparam logic [2:0] C_IMM_BRANCH = 3'd3;
    localparam logic [2:0] C_IMM_UPPER  = 3'd4;
    localparam logic [2:0] C_IMM_JAL    = 3'd5;
    localparam logic [2:0] C_IMM_CSR    = 3'd6;
    localparam logic [2:0] C_IMM_JALR   = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_CSR_WAIT = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic [2:0] imm_type;
        logic       illegal;
        logic       is_system;
    } dec_info_t;

    function automatic dec_info_t decode_opcode(input logic [6:0] opcode,
                                                input logic [2:0] funct3);
        dec_info_t info;
        info = '0;
        case (opcode)
            C_OPC_OP_IMM,
            C_OPC_OP,
            C_OPC_FENCE:  info.imm_type = C_IMM_OP_IMM;
            C_OPC_LOAD:   info.imm_type = C_IMM_LOAD;
            C_OPC_STORE:  info.imm_type = C_IMM_STORE;
            C_OPC_BRANCH: info.imm_type = C_IMM_BRANCH;
            C_OPC_LUI,
            C_OPC_AUIPC:  info.imm_type = C_IMM_UPPER;
            C_OPC_JAL:    info.imm_type = C_IMM_JAL;
            C_OPC_JALR:   info.imm_type = C_IMM_JALR;
            C_OPC_SYSTEM: begin
                info.is_system = 1'b1;
                // Only the immediate CSR forms carry a zimm operand.
                info.imm_type  = funct3[2] ? C_IMM_CSR : C_IMM_OP_IMM;
            end
            default:      info.illegal = 1'b1;
        endcase
        return info;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_generator.sv
// ============================================================================
// Module   : imm_generator
// Brief    : Forms the 32-bit immediate from instr[31:7] and a format code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imm_generator
    import riscv_pkg::*;
(
    input  logic [31:7] instr_in,
    input  logic [2:0]  imm_type_in,
    output logic [31:0] imm_out
);

    always_comb begin
        imm_out = {{20{instr_in[31]}}, instr_in[31:20]};
        case (imm_type_in)
            C_IMM_STORE:  imm_out = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            C_IMM_BRANCH: imm_out = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                                     instr_in[30:25], instr_in[11:8], 1'b0};
            C_IMM_UPPER:  imm_out = {instr_in[31:12], 12'b0};
            C_IMM_JAL:    imm_out = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                                     instr_in[20], instr_in[30:21], 1'b0};
            C_IMM_CSR:    imm_out = {27'b0, instr_in[19:15]};
            default:      imm_out = {{20{instr_in[31]}}, instr_in[31:20]};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_ctrl.sv
// ============================================================================
// Module   : decode_ctrl
// Brief    : Single-entry decode stage with CSR serialisation and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_ctrl
    import riscv_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_valid_in,
    input  logic [31:0] if_instr_in,
    input  logic [31:0] if_pc_in,
    output logic        id_ready_out,
    input  logic        ex_ready_in,
    input  logic        flush_in,
    input  logic        csr_done_in,
    output logic        id_valid_out,
    output logic [31:0] id_instr_out,
    output logic [31:0] id_pc_out,
    output logic [31:0] imm_out,
    output logic [2:0]  imm_type_out,
    output logic        illegal_out,
    output logic        csr_busy_out
);

    dec_state_t  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic [2:0]  imm_type_q, imm_type_d;
    logic        illegal_q, illegal_d;
    logic        is_sys_q, is_sys_d;

    dec_info_t   dec;
    logic [31:0] imm_new;
    logic        xfer;

    assign dec = decode_opcode(if_instr_in[6:0], if_instr_in[14:12]);

    imm_generator u_imm_gen (
        .instr_in    (if_instr_in[31:7]),
        .imm_type_in (dec.imm_type),
        .imm_out     (imm_new)
    );

    always_comb begin
        state_d      = state_q;
        id_ready_out = 1'b0;
        case (state_q)
            ST_EMPTY:    id_ready_out = 1'b1;
            ST_FULL:     id_ready_out = !is_sys_q && ex_ready_in;
            ST_CSR_WAIT: id_ready_out = 1'b0;
            default:     id_ready_out = 1'b0;
        endcase
        // A cycle that is being flushed or reset must not look like a handshake upstream.
        if (flush_in || rst_in) begin
            id_ready_out = 1'b0;
        end
        xfer = if_valid_in && id_ready_out;

        case (state_q)
            ST_EMPTY: begin
                if (xfer) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (is_sys_q) begin
                    if (ex_ready_in) state_d = ST_CSR_WAIT;
                end else if (ex_ready_in) begin
                    state_d = xfer ? ST_FULL : ST_EMPTY;
                end
            end
            ST_CSR_WAIT: begin
                if (csr_done_in) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_in) begin
            state_d = ST_EMPTY;
        end

        instr_d    = xfer ? if_instr_in   : instr_q;
        pc_d       = xfer ? if_pc_in      : pc_q;
        imm_d      = xfer ? imm_new       : imm_q;
        imm_type_d = xfer ? dec.imm_type  : imm_type_q;
        illegal_d  = xfer ? dec.illegal   : illegal_q;
        is_sys_d   = xfer ? dec.is_system : is_sys_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_EMPTY;
            instr_q    <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            imm_type_q <= '0;
            illegal_q  <= 1'b0;
            is_sys_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            imm_type_q <= imm_type_d;
            illegal_q  <= illegal_d;
            is_sys_q   <= is_sys_d;
        end
    end

    assign id_valid_out = (state_q == ST_FULL);
    assign csr_busy_out = (state_q == ST_CSR_WAIT);
    assign id_instr_out = instr_q;
    assign id_pc_out    = pc_q;
    assign imm_out      = imm_q;
    assign imm_type_out = imm_type_q;
    assign illegal_out  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl.sv
// ============================================================================
// Module   : tb_decode_ctrl
// Brief    : Directed and randomised checks of decode_ctrl against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, if_valid_in, ex_ready_in, flush_in, csr_done_in;
    logic [31:0] if_instr_in, if_pc_in;
    logic        id_ready_out, id_valid_out, illegal_out, csr_busy_out;
    logic [31:0] id_instr_out, id_pc_out, imm_out;
    logic [2:0]  imm_type_out;

    always #5 clk_in = ~clk_in;

    decode_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .if_valid_in  (if_valid_in),
        .if_instr_in  (if_instr_in),
        .if_pc_in     (if_pc_in),
        .id_ready_out (id_ready_out),
        .ex_ready_in  (ex_ready_in),
        .flush_in     (flush_in),
        .csr_done_in  (csr_done_in),
        .id_valid_out (id_valid_out),
        .id_instr_out (id_instr_out),
        .id_pc_out    (id_pc_out),
        .imm_out      (imm_out),
        .imm_type_out (imm_type_out),
        .illegal_out  (illegal_out),
        .csr_busy_out (csr_busy_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: "is something held", "is a CSR retiring", and the held contents.
    bit          m_held, m_wait, m_sys, m_ill;
    logic [31:0] m_instr, m_pc, m_imm;
    logic [2:0]  m_type;
    bit          last_ready;

    localparam logic [31:0] C_ADDI   = 32'hFFF00093;
    localparam logic [31:0] C_SW     = 32'h00112623;
    localparam logic [31:0] C_BEQ    = 32'hFE000EE3;
    localparam logic [31:0] C_LUI    = 32'h123452B7;
    localparam logic [31:0] C_CSRRWI = 32'h3002D073;
    localparam logic [31:0] C_ILL    = 32'h00000007;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                       output logic [2:0] ty, output bit ill);
        logic [11:0] i_f, s_f;
        logic [12:0] b_f;
        logic [20:0] j_f;
        i_f = ins[31:20];
        s_f = {ins[31:25], ins[11:7]};
        b_f = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j_f = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm = 32'($signed(i_f));
        ty  = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h33, 7'h0F: ;
            7'h03: ty = 3'd1;
            7'h23: begin ty = 3'd2; imm = 32'($signed(s_f)); end
            7'h63: begin ty = 3'd3; imm = 32'($signed(b_f)); end
            7'h37, 7'h17: begin ty = 3'd4; imm = ins & 32'hFFFFF000; end
            7'h6F: begin ty = 3'd5; imm = 32'($signed(j_f)); end
            7'h67: ty = 3'd7;
            7'h73: if (ins[14]) begin ty = 3'd6; imm = 32'(ins[19:15]); end
            default: ill = 1'b1;
        endcase
    endfunction

    // Apply one cycle of inputs (entered and left at the falling edge).
    task automatic cycle(input bit rst, input bit flush, input bit iv, input logic [31:0] ins,
                         input logic [31:0] pc, input bit exr, input bit csrd);
        bit exp_ready, xfer;
        rst_in = rst; flush_in = flush; if_valid_in = iv; if_instr_in = ins;
        if_pc_in = pc; ex_ready_in = exr; csr_done_in = csrd;
        #1;
        exp_ready = !rst && !flush && !m_wait && (!m_held || (!m_sys && exr));
        check("id_ready", {31'b0, id_ready_out}, {31'b0, exp_ready});
        last_ready = id_ready_out;
        xfer = iv && exp_ready;
        if (rst) begin
            m_held = 0; m_wait = 0; m_sys = 0; m_ill = 0;
            m_instr = '0; m_pc = '0; m_imm = '0; m_type = '0;
        end else if (flush) begin
            m_held = 0; m_wait = 0;
        end else if (m_wait) begin
            if (csrd) m_wait = 0;
        end else if (m_held && m_sys) begin
            if (exr) begin m_held = 0; m_wait = 1; end
        end else begin
            if (m_held && exr) m_held = 0;
            if (xfer) begin
                ref_decode(ins, m_imm, m_type, m_ill);
                m_held = 1; m_instr = ins; m_pc = pc; m_sys = (ins[6:0] == 7'h73);
            end
        end
        @(posedge clk_in);
        #1;
        check("id_valid", {31'b0, id_valid_out}, {31'b0, m_held});
        check("csr_busy", {31'b0, csr_busy_out}, {31'b0, m_wait});
        check("id_instr", id_instr_out, m_instr);
        check("id_pc", id_pc_out, m_pc);
        check("imm", imm_out, m_imm);
        check("imm_type", {29'b0, imm_type_out}, {29'b0, m_type});
        check("illegal", {31'b0, illegal_out}, {31'b0, m_ill});
        @(negedge clk_in);
    endtask

    task automatic idle(input bit exr);
        cycle(0, 0, 0, 32'h0, 32'h0, exr, 0);
    endtask

    logic [6:0] opc_tab [13] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                                 7'h67, 7'h33, 7'h0F, 7'h73, 7'h07, 7'h7F};

    initial begin
        rst_in = 1; flush_in = 0; if_valid_in = 0; if_instr_in = '0; if_pc_in = '0;
        ex_ready_in = 0; csr_done_in = 0;
        @(negedge clk_in);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, C_ADDI, 0, 0, 0);

        // addi then idle
        cycle(0, 0, 1, C_ADDI, 32'h100, 0, 0);
        check("addi_valid", {31'b0, id_valid_out}, 32'd1);
        check("addi_imm", imm_out, 32'hFFFFFFFF);
        check("addi_type", {29'b0, imm_type_out}, 32'd0);
        check("addi_illegal", {31'b0, illegal_out}, 32'd0);
        idle(1);

        // sw, beq, lui back-to-back
        cycle(0, 0, 1, C_SW, 32'h200, 1, 0);
        check("sw_imm", imm_out, 32'h0000000C);
        check("sw_type", {29'b0, imm_type_out}, 32'd2);
        cycle(0, 0, 1, C_BEQ, 32'h204, 1, 0);
        check("beq_imm", imm_out, 32'hFFFFFFFC);
        check("beq_type", {29'b0, imm_type_out}, 32'd3);
        check("beq_valid", {31'b0, id_valid_out}, 32'd1);
        cycle(0, 0, 1, C_LUI, 32'h208, 1, 0);
        check("lui_imm", imm_out, 32'h12345000);
        check("lui_type", {29'b0, imm_type_out}, 32'd4);
        idle(1);

        // csrrwi then addi
        cycle(0, 0, 1, C_CSRRWI, 32'h300, 0, 0);
        check("csr_imm", imm_out, 32'h00000005);
        check("csr_type", {29'b0, imm_type_out}, 32'd6);
        cycle(0, 0, 1, C_ADDI, 32'h304, 1, 0);
        check("csr_ready_full", {31'b0, last_ready}, 32'd0);
        check("csr_busy", {31'b0, csr_busy_out}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 1, C_ADDI, 32'h304, 1, 0);
            check("csr_wait_ready", {31'b0, last_ready}, 32'd0);
        end
        cycle(0, 0, 1, C_ADDI, 32'h304, 1, 1);
        check("csr_done_ready", {31'b0, last_ready}, 32'd0);
        cycle(0, 0, 1, C_ADDI, 32'h304, 1, 0);
        check("post_csr_ready", {31'b0, last_ready}, 32'd1);
        check("post_csr_imm", imm_out, 32'hFFFFFFFF);
        idle(1);

        // stall while FULL
        cycle(0, 0, 1, C_SW, 32'h400, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, C_LUI, 32'h404, 0, 0);
            check("stall_ready", {31'b0, last_ready}, 32'd0);
            check("stall_imm", imm_out, 32'h0000000C);
        end

        // flush with incoming instruction while FULL
        cycle(0, 1, 1, C_BEQ, 32'h408, 1, 0);
        check("flush_ready", {31'b0, last_ready}, 32'd0);
        check("flush_valid", {31'b0, id_valid_out}, 32'd0);

        // illegal opcode
        cycle(0, 0, 1, C_ILL, 32'h500, 0, 0);
        check("ill_flag", {31'b0, illegal_out}, 32'd1);
        check("ill_type", {29'b0, imm_type_out}, 32'd0);
        idle(1);

        // reset taken in CSR_WAIT
        cycle(0, 0, 1, C_CSRRWI, 32'h600, 0, 0);
        idle(1);
        check("rst_pre_busy", {31'b0, csr_busy_out}, 32'd1);
        cycle(1, 1, 1, C_ADDI, 32'h604, 1, 1);
        check("rst_busy", {31'b0, csr_busy_out}, 32'd0);
        check("rst_imm", imm_out, 32'h0);
        idle(0);
        check("rst_ready", {31'b0, last_ready}, 32'd1);

        // randomised traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            ins = {$urandom() >> 7, 7'b0} | {25'b0, opc_tab[$urandom_range(12, 0)]};
            cycle(($urandom_range(99, 0) == 0), ($urandom_range(15, 0) == 0),
                  ($urandom_range(3, 0) != 0), ins, $urandom(),
                  ($urandom_range(2, 0) != 0), ($urandom_range(3, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Ports SHALL be, clock and reset first: clk_in  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-002 rst_in  input  1  reset, synchronous, active-high.
REQ-003 if_valid_in  input  1  fetch presents a valid instruction.
REQ-004 if_instr_in  input  32  fetched instruction word.
REQ-005 if_pc_in  input  32  PC of the fetched instruction.
REQ-006 id_ready_out  output  1  decode accepts this cycle; a transfer occurs when if_valid_in && id_ready_out.
REQ-007 ex_ready_in  input  1  execute consumes the held instruction this cycle.
REQ-008 flush_in  input  1  discard the held and incoming instruction (branch/trap redirect).
REQ-009 csr_done_in  input  1  execute signals that a CSR/SYSTEM instruction has retired.
REQ-010 id_valid_out  output  1  held instruction valid toward execute.
REQ-011 id_instr_out, id_pc_out  output  32 each  registered instruction and PC.
REQ-012 imm_out  output  32  registered sign-extended immediate of the held instruction.
REQ-013 imm_type_out  output  3  registered immediate-format code of the held instruction.
REQ-014 illegal_out  output  1  held instruction has an unsupported opcode; qualified by id_valid_out.
REQ-015 csr_busy_out  output  1  high while in state CSR_WAIT.

Function
REQ-016 Immediate type codes SHALL be: OP-IMM 0, LOAD 1, STORE 2, BRANCH 3, LUI/AUIPC 4, JAL 5, SYSTEM with funct3[2]=1 6, JALR 7; OP, FENCE and SYSTEM with funct3[2]=0 SHALL encode 0.
REQ-017 Any other opcode[6:0] SHALL encode 0 with illegal_out=1.
REQ-018 Immediate formats: I = sign-extended instr[31:20]; S = {instr[31:25],instr[11:7]} sign-extended; B = {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended; CSR = zero-extended instr[19:15].
REQ-019 Immediate, type and illegal flag SHALL be computed from if_instr_in and registered on transfer; latency from transfer to id_valid_out is 1 cycle.
REQ-020 The FSM SHALL have the states EMPTY, FULL and CSR_WAIT.
REQ-021 EMPTY: id_ready_out=1; on transfer -> FULL.
REQ-022 FULL, held instruction not SYSTEM: id_ready_out=ex_ready_in; on ex_ready_in with a transfer, stay FULL with the new instruction (back-to-back, no bubble); on ex_ready_in without a transfer -> EMPTY; without ex_ready_in, hold all outputs stable.
REQ-023 FULL, held instruction SYSTEM: id_ready_out=0; on ex_ready_in -> CSR_WAIT and id_valid_out falls.
REQ-024 CSR_WAIT: id_ready_out=0 and id_valid_out=0; on csr_done_in -> EMPTY (no accept in the same cycle).
REQ-025 flush_in SHALL have priority over all other events: id_ready_out=0 in that cycle, next state EMPTY, id_valid_out=0 next cycle, from any state.
REQ-026 csr_done_in outside CSR_WAIT SHALL be ignored.
REQ-027 Data outputs SHALL not change while id_valid_out=1 and ex_ready_in=0.

Reset
REQ-028 rst_in SHALL force state EMPTY and all outputs to 0 on the next edge, except id_ready_out, which is 1 after reset.
REQ-029 rst_in SHALL override flush_in, csr_done_in and any in-flight transfer; a reset taken in CSR_WAIT abandons the wait.

Structure
REQ-030 A shared package riscv_pkg SHALL hold the opcode constants, the imm-type code constants of REQ-016 and the FSM state typedef.
REQ-031 The immediate formation SHALL be one instantiated sub-module, imm_generator (instr[31:7] and 3-bit type in, 32-bit immediate out), feeding the capture registers.

Verification
REQ-032 The bench SHALL cover addi 0xFFF00093 then idle -> next cycle id_valid_out=1, imm_out=0xFFFFFFFF, imm_type_out=0, illegal_out=0.
REQ-033 The bench SHALL cover sw 0x00112623, beq 0xFE000EE3 and lui 0x123452B7 back-to-back with ex_ready_in=1 -> imm_out 0x0000000C/2, 0xFFFFFFFC/3, 0x12345000/4 on consecutive cycles, with no bubble.
REQ-034 The bench SHALL cover csrrwi 0x3002D073 followed by addi -> imm_out=0x00000005, type 6; after the ex_ready_in handshake, csr_busy_out=1 and id_ready_out=0 until csr_done_in; addi accepted only the cycle after return to EMPTY.
REQ-035 The bench SHALL cover ex_ready_in=0 for 3 cycles while FULL -> all outputs stable, id_ready_out=0.
REQ-036 The bench SHALL cover flush_in asserted simultaneously with if_valid_in in FULL -> incoming instruction dropped, id_valid_out=0 next cycle.
REQ-037 The bench SHALL cover opcode 0x00000007 -> illegal_out=1, and rst_in asserted in CSR_WAIT -> EMPTY, outputs 0, id_ready_out=1.
